// File: rtl/arb_pkg.sv
// Shared types and width helpers for the locking round-robin arbiter.
package arb_pkg;

    // Arbiter FSM: free arbitration, or a burst pinned to one requester.
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Index and counter registers never shrink below one bit.
    localparam int MIN_W = 1;

    // Bits needed to hold the values 0..n-1.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : MIN_W;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Masked round-robin search: the first valid requester above `last`,
// otherwise the lowest valid requester, otherwise N-1 when nothing is valid.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     valid,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] idx
);

    logic [N-1:0] above;

    // Later loops override earlier results, so the masked winner has priority.
    always_comb begin
        above = '0;
        idx   = IDX_W'(N - 1);
        for (int i = 0; i < N; i++) begin
            above[i] = valid[i] && (IDX_W'(i) > last);
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (valid[i]) idx = IDX_W'(i);
        end
        if (|above) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (above[i]) idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/locking_rr_arbiter.sv
// Round-robin arbiter that holds its grant for BEATS transfers once a
// requester wins. Pure mux datapath: zero latency, no buffering.
// Optional macro LOCK_TIMEOUT_EN: a lock stalled by its owner for TIMEOUT
// consecutive cycles is dropped, with a one-cycle io_timeout pulse.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | round-robin pick each cycle; a fire starts a burst
//   LOCKED | grant pinned to lock_q until BEATS fires (or timeout)
module locking_rr_arbiter
    import arb_pkg::*;
#(
    parameter int N       = 4,
    parameter int W       = 8,
    parameter int BEATS   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         io_in_valid,
    input  logic [N*W-1:0]       io_in_bits,
    output logic [N-1:0]         io_in_ready,
    output logic                 io_out_valid,
    input  logic                 io_out_ready,
    output logic [W-1:0]         io_out_bits,
    output logic [$clog2(N)-1:0] io_chosen,
    output logic                 io_locked,
    output logic                 io_timeout
);

    localparam int IDX_W = idx_width(N);
    localparam int CNT_W = idx_width(BEATS);

    if (N < 2 || BEATS < 1 || TIMEOUT < 1) begin : g_bad_params
        $error("locking_rr_arbiter: illegal parameter values");
    end

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [IDX_W-1:0] lock_q, lock_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] chosen;
    logic             fire;

    rr_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .valid (io_in_valid),
        .last  (last_q),
        .idx   (pick_idx)
    );

    assign chosen    = (state_q == LOCKED) ? lock_q : pick_idx;
    assign io_chosen = chosen;
    assign io_locked = (state_q == LOCKED);
    assign fire      = io_out_valid & io_out_ready;

    // Output mux; io_out_valid never depends on io_out_ready.
    always_comb begin
        io_out_valid = 1'b0;
        io_out_bits  = '0;
        io_in_ready  = '0;
        for (int i = 0; i < N; i++) begin
            if (IDX_W'(i) == chosen) begin
                io_out_valid   = io_in_valid[i];
                io_out_bits    = io_in_bits[i*W +: W];
                io_in_ready[i] = io_out_ready;
            end
        end
    end

`ifdef LOCK_TIMEOUT_EN
    localparam int TO_W = idx_width(TIMEOUT);

    logic [TO_W-1:0] tcnt_q, tcnt_d;
    logic            timeout_q, timeout_d;

    assign io_timeout = timeout_q;
`else
    assign io_timeout = 1'b0;
`endif

    // Next-state logic: burst entry, beat counting and (optionally) stall timeout.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        lock_d  = lock_q;
        cnt_d   = cnt_q;
`ifdef LOCK_TIMEOUT_EN
        tcnt_d    = '0;
        timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (fire) begin
                    last_d = chosen;
                    if (BEATS > 1) begin
                        state_d = LOCKED;
                        lock_d  = chosen;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            LOCKED: begin
                if (fire) begin
                    if (cnt_q == CNT_W'(BEATS - 1)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`ifdef LOCK_TIMEOUT_EN
                // last_q already equals lock_q, so a forced unlock rotates past it.
                else if (!io_in_valid[lock_q]) begin
                    if (tcnt_q == TO_W'(TIMEOUT - 1)) begin
                        state_d   = IDLE;
                        cnt_d     = '0;
                        timeout_d = 1'b1;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset abandons any burst and gives input 0 top priority.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            last_q  <= IDX_W'(N - 1);
            lock_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            lock_q  <= lock_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef LOCK_TIMEOUT_EN
    // Stall counter and registered timeout pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcnt_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            tcnt_q    <= tcnt_d;
            timeout_q <= timeout_d;
        end
    end
`endif

endmodule
